// File: rtl/fetch_unit_if.sv
// Fetch-side buses: instruction-memory req/ack and the decode valid/ready handshake.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;

   modport master (
      output imem_req, imem_addr, inst, inst_valid,
      input  imem_ack, imem_rdata, inst_ready
   );

   modport slave (
      input  imem_req, imem_addr, inst, inst_valid,
      output imem_ack, imem_rdata, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Owns the architectural PC and sequences fetch: IDLE -> REQ -> HOLD -> REQ ..., and HALT on STOP or timeout.
// All state, including the synchronous reset, updates on the falling clock edge.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   output logic [31:0]       pc,
   input  logic [31:0]       next_pc,
   input  logic [1:0]        pc_inc,
   fetch_unit_if.master      fbus,
   output logic              halted,
   output logic              mem_err,
   output logic [31:0]       fetch_count
);

   localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
   localparam logic [1:0] PC_STOP = 2'b11;

   typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;

   always_comb begin
      fbus.imem_addr = pc;
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state           <= IDLE;
         pc              <= RESET_PC;
         fbus.inst       <= '0;
         fbus.inst_valid <= 1'b0;
         fbus.imem_req   <= 1'b0;
         halted          <= 1'b0;
         mem_err         <= 1'b0;
         fetch_count     <= '0;
         wait_cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt      <= '0;
               fbus.imem_req <= 1'b1;
               state         <= REQ;
            end
            REQ: begin
               // An ack on the final allowed cycle still wins over the timeout.
               if (fbus.imem_ack) begin
                  fbus.inst       <= fbus.imem_rdata;
                  fbus.inst_valid <= 1'b1;
                  fbus.imem_req   <= 1'b0;
                  wait_cnt        <= '0;
                  state           <= HOLD;
               end else if (wait_cnt == WAIT_LAST) begin
                  mem_err       <= 1'b1;
                  halted        <= 1'b1;
                  fbus.imem_req <= 1'b0;
                  state         <= HALT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (fbus.inst_ready) begin
                  fetch_count     <= fetch_count + 32'd1;
                  fbus.inst_valid <= 1'b0;
                  if (pc_inc != PC_STOP) begin
                     pc            <= next_pc;
                     wait_cnt      <= '0;
                     fbus.imem_req <= 1'b1;
                     state         <= REQ;
                  end else begin
                     halted <= 1'b1;
                     state  <= HALT;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for the main flow plus hand-written multi-cycle sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [1:0]  pc_inc;
   logic        halted;
   logic        mem_err;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h10), .MAX_WAIT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .next_pc     (next_pc),
      .pc_inc      (pc_inc),
      .fbus        (bus.master),
      .halted      (halted),
      .mem_err     (mem_err),
      .fetch_count (fetch_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rst;
      logic [31:0] ack;
      logic [31:0] rdata;
      logic [31:0] ready;
      logic [31:0] inc;
      logic [31:0] npc;
      logic [31:0] req;
      logic [31:0] valid;
      logic [31:0] inst;
      logic [31:0] halted;
      logic [31:0] err;
      logic [31:0] pc;
      logic [31:0] fc;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs are applied now and take effect at the next falling edge; outputs are read 1ns after it.
   task automatic step(input logic r, input logic a, input logic [31:0] rd,
                       input logic rdy, input logic [1:0] inc, input logic [31:0] npc);
      rst            = r;
      bus.imem_ack   = a;
      bus.imem_rdata = rd;
      bus.inst_ready = rdy;
      pc_inc         = inc;
      next_pc        = npc;
      @(negedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic req, input logic valid,
                            input logic hlt, input logic err, input logic [31:0] epc);
      chk({tag, "_req"},    {31'b0, bus.imem_req},   {31'b0, req});
      chk({tag, "_valid"},  {31'b0, bus.inst_valid}, {31'b0, valid});
      chk({tag, "_halted"}, {31'b0, halted},         {31'b0, hlt});
      chk({tag, "_err"},    {31'b0, mem_err},        {31'b0, err});
      chk({tag, "_pc"},     pc,                      epc);
      chk({tag, "_addr"},   bus.imem_addr,           epc);
   endtask

   initial begin
      //            rst ack rdata     rdy inc npc        req val inst      hlt err pc     fc
      vecs[0]  = '{32'd1, 32'd0, 32'h0,    32'd0, 32'd0, 32'h0,   32'd0, 32'd0, 32'h0,  32'd0, 32'd0, 32'h10, 32'd0};
      vecs[1]  = '{32'd0, 32'd0, 32'h0,    32'd0, 32'd0, 32'h0,   32'd1, 32'd0, 32'h0,  32'd0, 32'd0, 32'h10, 32'd0};
      vecs[2]  = '{32'd0, 32'd1, 32'hA0,   32'd0, 32'd0, 32'h0,   32'd0, 32'd1, 32'hA0, 32'd0, 32'd0, 32'h10, 32'd0};
      vecs[3]  = '{32'd0, 32'd0, 32'h0,    32'd1, 32'd0, 32'h11,  32'd1, 32'd0, 32'hA0, 32'd0, 32'd0, 32'h11, 32'd1};
      vecs[4]  = '{32'd0, 32'd1, 32'hA1,   32'd0, 32'd0, 32'h0,   32'd0, 32'd1, 32'hA1, 32'd0, 32'd0, 32'h11, 32'd1};
      vecs[5]  = '{32'd0, 32'd0, 32'h0,    32'd1, 32'd0, 32'h12,  32'd1, 32'd0, 32'hA1, 32'd0, 32'd0, 32'h12, 32'd2};
      vecs[6]  = '{32'd0, 32'd1, 32'hA2,   32'd0, 32'd0, 32'h0,   32'd0, 32'd1, 32'hA2, 32'd0, 32'd0, 32'h12, 32'd2};
      vecs[7]  = '{32'd0, 32'd0, 32'h0,    32'd1, 32'd0, 32'h13,  32'd1, 32'd0, 32'hA2, 32'd0, 32'd0, 32'h13, 32'd3};
      vecs[8]  = '{32'd0, 32'd1, 32'hB0,   32'd0, 32'd0, 32'h0,   32'd0, 32'd1, 32'hB0, 32'd0, 32'd0, 32'h13, 32'd3};
      vecs[9]  = '{32'd0, 32'd0, 32'h0,    32'd1, 32'd1, 32'h40,  32'd1, 32'd0, 32'hB0, 32'd0, 32'd0, 32'h40, 32'd4};
      vecs[10] = '{32'd0, 32'd1, 32'hB1,   32'd0, 32'd0, 32'h0,   32'd0, 32'd1, 32'hB1, 32'd0, 32'd0, 32'h40, 32'd4};
      vecs[11] = '{32'd0, 32'd0, 32'h0,    32'd1, 32'd2, 32'h80,  32'd1, 32'd0, 32'hB1, 32'd0, 32'd0, 32'h80, 32'd5};
      vecs[12] = '{32'd0, 32'd0, 32'h0,    32'd1, 32'd0, 32'h90,  32'd1, 32'd0, 32'hB1, 32'd0, 32'd0, 32'h80, 32'd5};
      vecs[13] = '{32'd0, 32'd1, 32'hC0,   32'd0, 32'd0, 32'h0,   32'd0, 32'd1, 32'hC0, 32'd0, 32'd0, 32'h80, 32'd5};
      vecs[14] = '{32'd0, 32'd1, 32'hDEAD, 32'd0, 32'd3, 32'h99,  32'd0, 32'd1, 32'hC0, 32'd0, 32'd0, 32'h80, 32'd5};
      vecs[15] = '{32'd0, 32'd0, 32'h0,    32'd1, 32'd3, 32'h99,  32'd0, 32'd0, 32'hC0, 32'd1, 32'd0, 32'h80, 32'd6};
      vecs[16] = '{32'd0, 32'd1, 32'h77,   32'd1, 32'd0, 32'h5,   32'd0, 32'd0, 32'hC0, 32'd1, 32'd0, 32'h80, 32'd6};

      rst = 1'b1;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = '0;
      bus.inst_ready = 1'b0;
      pc_inc = 2'b00;
      next_pc = '0;

      for (int i = 0; i < 17; i++) begin
         step(vecs[i].rst[0], vecs[i].ack[0], vecs[i].rdata, vecs[i].ready[0],
              vecs[i].inc[1:0], vecs[i].npc);
         chk($sformatf("v%0d_req", i),    {31'b0, bus.imem_req},   vecs[i].req);
         chk($sformatf("v%0d_valid", i),  {31'b0, bus.inst_valid}, vecs[i].valid);
         chk($sformatf("v%0d_inst", i),   bus.inst,                vecs[i].inst);
         chk($sformatf("v%0d_halted", i), {31'b0, halted},         vecs[i].halted);
         chk($sformatf("v%0d_err", i),    {31'b0, mem_err},        vecs[i].err);
         chk($sformatf("v%0d_pc", i),     pc,                      vecs[i].pc);
         if (vecs[i].req[0])
            chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].pc);
         chk($sformatf("v%0d_fc", i),     fetch_count,             vecs[i].fc);
      end

      // Halted after STOP: no request and frozen pc whatever the inputs do.
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b1, 32'h1234, 1'b1, 2'b01, 32'h200);
         chk_state($sformatf("halt%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
      end
      chk("halt_fc", fetch_count, 32'd6);

      // Reset resumes fetch; memory acks on the 4th REQ cycle; decode stalls 4 cycles.
      step(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      chk_state("rst1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
      chk("rst1_fc", fetch_count, 32'd0);
      chk("rst1_inst", bus.inst, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      chk_state("slow_req0", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 32'hBAD, 1'b0, 2'b00, 32'h0);
         chk_state($sformatf("slow_wait%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
      end
      step(1'b0, 1'b1, 32'h5A, 1'b0, 2'b00, 32'h0);
      chk_state("slow_ack", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
      chk("slow_ack_inst", bus.inst, 32'h5A);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 32'h66, 1'b0, 2'b00, 32'h20);
         chk_state($sformatf("stall%0d", i), 1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
         chk($sformatf("stall%0d_inst", i), bus.inst, 32'h5A);
         chk($sformatf("stall%0d_fc", i), fetch_count, 32'd0);
      end
      step(1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 32'h20);
      chk_state("stall_done", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
      chk("stall_done_fc", fetch_count, 32'd1);

      // Timeout: 15 REQ cycles without ack.
      for (int i = 0; i < 14; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
         chk_state($sformatf("to_wait%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
      end
      step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      chk_state("to_hit", 1'b0, 1'b0, 1'b1, 1'b1, 32'h20);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 32'h0, 1'b1, 2'b00, 32'h300);
         chk_state($sformatf("to_sticky%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, 32'h20);
      end

      // Ack exactly on the 15th REQ cycle wins over the timeout.
      step(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      chk_state("rst2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
      step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      chk_state("late_wait", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
      step(1'b0, 1'b1, 32'hF00D, 1'b0, 2'b00, 32'h0);
      chk_state("late_ack", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
      chk("late_ack_inst", bus.inst, 32'hF00D);

      // Reset overrides an accepting handshake in HOLD, then an ack in REQ.
      step(1'b1, 1'b0, 32'h0, 1'b1, 2'b00, 32'h77);
      chk_state("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
      chk("rst_hold_fc", fetch_count, 32'd0);
      chk("rst_hold_inst", bus.inst, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      chk_state("rst_req_pre", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
      step(1'b1, 1'b1, 32'hABCD, 1'b0, 2'b00, 32'h0);
      chk_state("rst_req", 1'b0, 1'b0, 1'b0, 1'b0, 32'h10);
      chk("rst_req_inst", bus.inst, 32'h0);

      // pc takes next_pc verbatim, including wrap from all-ones to zero.
      step(1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
      step(1'b0, 1'b1, 32'h1, 1'b0, 2'b00, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 2'b10, 32'hFFFF_FFFF);
      chk_state("wrap_hi", 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
      step(1'b0, 1'b1, 32'h2, 1'b0, 2'b00, 32'h0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 2'b00, 32'h0);
      chk_state("wrap_lo", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("wrap_fc", fetch_count, 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
